// File: rtl/snax_tcdm_bank_pkg.sv
// Shared types for the SNAX TCDM bank with in-bank atomics.
// Request/response bundles, AMO encodings and strobe decode helpers.
package snax_tcdm_bank_pkg;

  localparam int AmoLatency = 1;
  localparam int AddrW = 10;
  localparam int DataW = 64;
  localparam int StrbW = DataW / 8;
  localparam int UserW = 4;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

  typedef enum logic [1:0] {
    W32_LO,
    W32_HI,
    W64
  } amo_width_e;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic             write;
    amo_op_e          amo;
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic [UserW-1:0] user;
  } mem_q_t;

  typedef struct packed {
    logic   q_valid;
    mem_q_t q;
  } mem_req_t;

  typedef struct packed {
    logic [DataW-1:0] data;
  } mem_p_t;

  typedef struct packed {
    logic   q_ready;
    mem_p_t p;
  } mem_rsp_t;

  function automatic amo_width_e strb_to_amo_width(
    input logic [StrbW-1:0] strb
  );
    amo_width_e w;
    case (strb)
      8'h0F:   w = W32_LO;
      8'hF0:   w = W32_HI;
      default: w = W64;
    endcase
    return w;
  endfunction

  function automatic logic strb_is_amo(
    input logic [StrbW-1:0] strb
  );
    return (strb == 8'h0F) ||
           (strb == 8'hF0) ||
           (strb == 8'hFF);
  endfunction

  function automatic logic op_is_amo(
    input amo_op_e op
  );
    return (op != AMONone) &&
           (op != AMOLR) &&
           (op != AMOSC);
  endfunction

endpackage

// File: rtl/snax_amo_alu.sv
// Combinational AMO datapath for one 64-bit word.
// Operates on a 32-bit lane or the full word; other lane passes through.
module snax_amo_alu
  import snax_tcdm_bank_pkg::*;
(
  input  amo_op_e     op,
  input  amo_width_e  width,
  input  logic [63:0] old,
  input  logic [63:0] operand,
  output logic [63:0] result
);

  logic        hi;
  logic [31:0] a32;
  logic [31:0] b32;
  logic [31:0] r32;
  logic [63:0] r64;
  logic        lt32s;
  logic        lt32u;
  logic        lt64s;
  logic        lt64u;

  assign hi  = (width == W32_HI);
  assign a32 = hi ? old[63:32] : old[31:0];
  assign b32 = hi ? operand[63:32] : operand[31:0];

  assign lt32s = $signed(a32) < $signed(b32);
  assign lt32u = a32 < b32;
  assign lt64s = $signed(old) < $signed(operand);
  assign lt64u = old < operand;

  // 32-bit lane result
  always_comb begin
    r32 = a32;
    case (op)
      AMOSwap: r32 = b32;
      AMOAdd:  r32 = a32 + b32;
      AMOAnd:  r32 = a32 & b32;
      AMOOr:   r32 = a32 | b32;
      AMOXor:  r32 = a32 ^ b32;
      AMOMax:  r32 = lt32s ? b32 : a32;
      AMOMaxu: r32 = lt32u ? b32 : a32;
      AMOMin:  r32 = lt32s ? a32 : b32;
      AMOMinu: r32 = lt32u ? a32 : b32;
      default: r32 = a32;
    endcase
  end

  // 64-bit word result
  always_comb begin
    r64 = old;
    case (op)
      AMOSwap: r64 = operand;
      AMOAdd:  r64 = old + operand;
      AMOAnd:  r64 = old & operand;
      AMOOr:   r64 = old | operand;
      AMOXor:  r64 = old ^ operand;
      AMOMax:  r64 = lt64s ? operand : old;
      AMOMaxu: r64 = lt64u ? operand : old;
      AMOMin:  r64 = lt64s ? old : operand;
      AMOMinu: r64 = lt64u ? old : operand;
      default: r64 = old;
    endcase
  end

  // merge lane result back into the word
  always_comb begin
    result = r64;
    case (width)
      W32_LO:  result = {old[63:32], r32};
      W32_HI:  result = {r32, old[31:0]};
      default: result = r64;
    endcase
  end

endmodule

// File: rtl/snax_tcdm_amo_bank.sv
// Single TCDM bank: 1-cycle read-before-write SRAM with in-bank AMOs.
// An AMO stalls the port for one write-back cycle.
module snax_tcdm_amo_bank
  import snax_tcdm_bank_pkg::*;
#(
  parameter int  NumWords     = 1024,
  parameter int  MemAddrWidth = 10,
  parameter int  DataWidth    = 64,
  parameter type mem_req_t    = snax_tcdm_bank_pkg::mem_req_t,
  parameter type mem_rsp_t    = snax_tcdm_bank_pkg::mem_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  mem_req_t mem_req_i,
  output mem_rsp_t mem_rsp_o
);

  localparam int NumBytes = DataWidth / 8;

  typedef enum logic {
    IDLE,
    AMO_WB
  } state_e;

  state_e                  state;
  logic                    ready;
  logic [DataWidth-1:0]    rdata;
  logic [DataWidth-1:0]    mem [NumWords];

  logic [MemAddrWidth-1:0] amo_addr;
  amo_op_e                 amo_op;
  amo_width_e              amo_width;
  logic [DataWidth-1:0]    amo_operand;
  logic [NumBytes-1:0]     amo_strb;
  logic [DataWidth-1:0]    amo_res;

  logic [MemAddrWidth-1:0] addr;
  logic [DataWidth-1:0]    wdata;
  logic [NumBytes-1:0]     strb;
  logic                    accept;
  logic                    is_amo;
  logic                    plain_we;
  logic                    wb_we;
  logic                    unused_user;

  assign addr  = mem_req_i.q.addr[MemAddrWidth-1:0];
  assign wdata = mem_req_i.q.data;
  assign strb  = mem_req_i.q.strb;

  assign accept   = mem_req_i.q_valid & ready;
  assign is_amo   = accept &
                    op_is_amo(mem_req_i.q.amo) &
                    strb_is_amo(strb);
  assign plain_we = accept & mem_req_i.q.write & ~is_amo;
  assign wb_we    = (state == AMO_WB) & rst_ni;

  assign unused_user = ^mem_req_i.q.user;

  assign mem_rsp_o.q_ready = ready;
  assign mem_rsp_o.p.data  = rdata;

  snax_amo_alu i_alu (
    .op      (amo_op),
    .width   (amo_width),
    .old     (rdata),
    .operand (amo_operand),
    .result  (amo_res)
  );

  // byte-strobed array update: plain writes or AMO write-back
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumBytes; i++) begin
      if (plain_we && strb[i])
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      else if (wb_we && amo_strb[i])
        mem[amo_addr][i*8 +: 8] <= amo_res[i*8 +: 8];
    end
  end

  // port FSM, read-before-write response and pending AMO latch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ready       <= 1'b1;
      rdata       <= '0;
      amo_addr    <= '0;
      amo_op      <= AMONone;
      amo_width   <= W64;
      amo_operand <= '0;
      amo_strb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept)
            rdata <= mem[addr];
          if (is_amo) begin
            amo_addr    <= addr;
            amo_op      <= mem_req_i.q.amo;
            amo_width   <= strb_to_amo_width(strb);
            amo_operand <= wdata;
            amo_strb    <= strb;
            ready       <= 1'b0;
            state       <= AMO_WB;
          end
        end
        AMO_WB: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snax_tcdm_amo_bank.sv
// Self-checking bench for snax_tcdm_amo_bank.
// Directed scenarios plus randomized traffic against a word-level model.
module tb_snax_tcdm_amo_bank;
  import snax_tcdm_bank_pkg::*;

  logic     clk_i = 1'b0;
  logic     rst_ni = 1'b0;
  mem_req_t mreq;
  mem_rsp_t mrsp;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [63:0] model [16];

  snax_tcdm_amo_bank dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .mem_req_i (mreq),
    .mem_rsp_o (mrsp)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic req(
    input  logic [9:0]  a,
    input  logic        w,
    input  amo_op_e     op,
    input  logic [63:0] d,
    input  logic [7:0]  s,
    output logic [63:0] rd,
    output int          acc_cyc
  );
    bit done = 0;
    mreq.q_valid = 1'b1;
    mreq.q.addr  = a;
    mreq.q.write = w;
    mreq.q.amo   = op;
    mreq.q.data  = d;
    mreq.q.strb  = s;
    mreq.q.user  = 4'($urandom);
    acc_cyc = -1;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk_i);
      if (mrsp.q_ready) begin
        done = 1;
        acc_cyc = cyc;
      end
      @(posedge clk_i);
      #1;
    end
    mreq.q_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout addr=%0d never accepted", a);
    end
    rd = mrsp.p.data;
  endtask

  function automatic logic [63:0] ref_amo(
    input amo_op_e     op,
    input logic [7:0]  s,
    input logic [63:0] old,
    input logic [63:0] opd
  );
    logic [63:0] res;
    res = old;
    if (s == 8'hFF) begin
      longint          a = old;
      longint          b = opd;
      longint unsigned ua = old;
      longint unsigned ub = opd;
      case (op)
        AMOSwap: res = opd;
        AMOAdd:  res = ua + ub;
        AMOAnd:  res = old & opd;
        AMOOr:   res = old | opd;
        AMOXor:  res = old ^ opd;
        AMOMax:  res = (a > b) ? a : b;
        AMOMaxu: res = (ua > ub) ? ua : ub;
        AMOMin:  res = (a < b) ? a : b;
        AMOMinu: res = (ua < ub) ? ua : ub;
        default: res = old;
      endcase
    end else begin
      int          sh = (s == 8'h0F) ? 0 : 32;
      int          a = old[sh +: 32];
      int          b = opd[sh +: 32];
      int unsigned ua = old[sh +: 32];
      int unsigned ub = opd[sh +: 32];
      int unsigned r = ua;
      case (op)
        AMOSwap: r = ub;
        AMOAdd:  r = ua + ub;
        AMOAnd:  r = ua & ub;
        AMOOr:   r = ua | ub;
        AMOXor:  r = ua ^ ub;
        AMOMax:  r = (a > b) ? a : b;
        AMOMaxu: r = (ua > ub) ? ua : ub;
        AMOMin:  r = (a < b) ? a : b;
        AMOMinu: r = (ua < ub) ? ua : ub;
        default: r = ua;
      endcase
      res[sh +: 32] = r;
    end
    return res;
  endfunction

  task automatic test_reset();
    logic [63:0] rd;
    int c;
    rst_ni = 1'b0;
    #12;
    n_checks++;
    if (mrsp.q_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got=%b want=1", mrsp.q_ready);
    end
    n_checks++;
    if (mrsp.p.data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data got=%h want=0", mrsp.p.data);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    n_checks++;
    if (mrsp.q_ready !== 1'b1 || mrsp.p.data !== 64'h0) begin
      n_fail++;
      $display("FAIL release_idle got=%b/%h want=1/0",
               mrsp.q_ready, mrsp.p.data);
    end
    req(10'd5, 1'b1, AMONone, 64'hDEAD_BEEF_0123_4567, 8'hFF, rd, c);
    req(10'd5, 1'b0, AMONone, 64'h0, 8'hFF, rd, c);
    n_checks++;
    if (rd !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++;
      $display("FAIL write_read got=%h want=deadbeef01234567", rd);
    end
  endtask

  task automatic test_strb();
    logic [63:0] rd;
    int c;
    req(10'd7, 1'b1, AMONone, 64'h0, 8'hFF, rd, c);
    req(10'd7, 1'b1, AMONone, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, rd, c);
    n_checks++;
    if (rd !== 64'h0) begin
      n_fail++;
      $display("FAIL write_rsp_old got=%h want=0", rd);
    end
    req(10'd7, 1'b0, AMONone, 64'h0, 8'h00, rd, c);
    n_checks++;
    if (rd !== 64'h0000_0000_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL strb_lo got=%h want=00000000ffffffff", rd);
    end
  endtask

  task automatic test_amo_add();
    logic [63:0] rd;
    int c;
    req(10'd9, 1'b1, AMONone, 64'h0000_0001_0000_0005, 8'hFF, rd, c);
    req(10'd9, 1'b0, AMOAdd, 64'h3, 8'h0F, rd, c);
    n_checks++;
    if (rd !== 64'h0000_0001_0000_0005) begin
      n_fail++;
      $display("FAIL amo_add_rsp got=%h want=0000000100000005", rd);
    end
    n_checks++;
    if (mrsp.q_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL amo_stall got=%b want=0", mrsp.q_ready);
    end
    @(posedge clk_i);
    #1;
    n_checks++;
    if (mrsp.q_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL amo_unstall got=%b want=1", mrsp.q_ready);
    end
    req(10'd9, 1'b0, AMONone, 64'h0, 8'h00, rd, c);
    n_checks++;
    if (rd !== 64'h0000_0001_0000_0008) begin
      n_fail++;
      $display("FAIL amo_add_wb got=%h want=0000000100000008", rd);
    end
  endtask

  task automatic test_amo_minmax();
    logic [63:0] rd;
    int c;
    req(10'd3, 1'b1, AMONone, 64'h0000_0000_FFFF_FFFE, 8'hFF, rd, c);
    req(10'd3, 1'b0, AMOMax, 64'h1, 8'h0F, rd, c);
    req(10'd3, 1'b0, AMONone, 64'h0, 8'h00, rd, c);
    n_checks++;
    if (rd !== 64'h1) begin
      n_fail++;
      $display("FAIL amo_max_signed got=%h want=1", rd);
    end
    req(10'd3, 1'b1, AMONone, 64'h0000_0000_FFFF_FFFE, 8'hFF, rd, c);
    req(10'd3, 1'b0, AMOMaxu, 64'h1, 8'h0F, rd, c);
    req(10'd3, 1'b0, AMONone, 64'h0, 8'h00, rd, c);
    n_checks++;
    if (rd !== 64'h0000_0000_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL amo_maxu got=%h want=fffffffe", rd);
    end
    req(10'd3, 1'b1, AMONone, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, c);
    req(10'd3, 1'b0, AMOAdd, 64'h2, 8'hFF, rd, c);
    req(10'd3, 1'b0, AMONone, 64'h0, 8'h00, rd, c);
    n_checks++;
    if (rd !== 64'h1) begin
      n_fail++;
      $display("FAIL amo_add64_wrap got=%h want=1", rd);
    end
    req(10'd3, 1'b1, AMONone, 64'h0000_0000_FFFF_FFFF, 8'hFF, rd, c);
    req(10'd3, 1'b0, AMOAdd, 64'h2, 8'h0F, rd, c);
    req(10'd3, 1'b0, AMONone, 64'h0, 8'h00, rd, c);
    n_checks++;
    if (rd !== 64'h1) begin
      n_fail++;
      $display("FAIL amo_add32_wrap got=%h want=1", rd);
    end
  endtask

  task automatic test_random();
    logic [63:0] rd;
    logic [63:0] exp;
    logic [63:0] d;
    logic [7:0]  s;
    logic [9:0]  a;
    logic        w;
    amo_op_e     op;
    int          c;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      model[i] = d;
      req(10'(i), 1'b1, AMONone, d, 8'hFF, rd, c);
    end
    for (int n = 0; n < 80; n++) begin
      a  = 10'($urandom_range(0, 15));
      op = amo_op_e'(4'($urandom_range(0, 11)));
      w  = 1'($urandom);
      d  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: s = 8'h0F;
        1: s = 8'hF0;
        2: s = 8'hFF;
        default: s = 8'($urandom);
      endcase
      exp = model[a];
      req(a, w, op, d, s, rd, c);
      n_checks++;
      if (rd !== exp) begin
        n_fail++;
        $display("FAIL rand_rsp n=%0d op=%0d strb=%h got=%h want=%h",
                 n, op, s, rd, exp);
      end
      if (op >= AMOSwap && op <= AMOMinu &&
          (s == 8'h0F || s == 8'hF0 || s == 8'hFF)) begin
        model[a] = ref_amo(op, s, exp, d);
      end else if (w) begin
        for (int b = 0; b < 8; b++)
          if (s[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd;
    logic [63:0] sw;
    int c0;
    int c1;
    int acc;
    sw = {$urandom, $urandom};
    req(10'd2, 1'b0, AMOSwap, sw, 8'hFF, rd, c0);
    n_checks++;
    if (rd !== model[2]) begin
      n_fail++;
      $display("FAIL swap_rsp got=%h want=%h", rd, model[2]);
    end
    model[2] = sw;
    req(10'd2, 1'b0, AMONone, 64'h0, 8'h00, rd, c1);
    n_checks++;
    if (c1 - c0 != 2) begin
      n_fail++;
      $display("FAIL swap_accept_gap got=%0d want=2", c1 - c0);
    end
    n_checks++;
    if (rd !== sw) begin
      n_fail++;
      $display("FAIL swap_read got=%h want=%h", rd, sw);
    end
    acc = 0;
    mreq.q_valid = 1'b1;
    mreq.q.write = 1'b0;
    mreq.q.amo   = AMONone;
    mreq.q.strb  = 8'h00;
    for (int i = 0; i < 16; i++) begin
      mreq.q.addr = 10'(i);
      @(negedge clk_i);
      if (mrsp.q_ready) acc++;
      @(posedge clk_i);
      #1;
      n_checks++;
      if (mrsp.p.data !== model[i]) begin
        n_fail++;
        $display("FAIL b2b_read a=%0d got=%h want=%h",
                 i, mrsp.p.data, model[i]);
      end
    end
    mreq.q_valid = 1'b0;
    n_checks++;
    if (acc != 16) begin
      n_fail++;
      $display("FAIL b2b_accepts got=%0d want=16", acc);
    end
  endtask

  task automatic test_reset_during_amo();
    logic [63:0] rd;
    int c;
    req(10'd4, 1'b1, AMONone, 64'h0F, 8'hFF, rd, c);
    req(10'd4, 1'b0, AMOOr, 64'hF0, 8'hFF, rd, c);
    n_checks++;
    if (mrsp.q_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_amo_inwb got=%b want=0", mrsp.q_ready);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (mrsp.q_ready !== 1'b1 || mrsp.p.data !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_amo_async got=%b/%h want=1/0",
               mrsp.q_ready, mrsp.p.data);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    n_checks++;
    if (mrsp.q_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_amo_release got=%b want=1", mrsp.q_ready);
    end
    req(10'd4, 1'b0, AMONone, 64'h0, 8'h00, rd, c);
    n_checks++;
    if (rd !== 64'h0F) begin
      n_fail++;
      $display("FAIL rst_amo_abort got=%h want=f", rd);
    end
  endtask

  initial begin
    mreq = '0;
    test_reset();
    test_strb();
    test_amo_add();
    test_amo_minmax();
    test_random();
    test_back_to_back();
    test_reset_during_amo();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
